// File: rtl/uart_cmd_ctrl_if.sv
// uart_cmd_ctrl_if: received-byte input and command/set-time outputs of uart_cmd_ctrl
//   i_rx_data/i_rx_done : byte from uart_rx, valid while i_rx_done is high
//   o_run_stop/o_clear/o_mode_tgl/o_set_valid/o_cmd_err : one-cycle pulses
//   o_set_hour/o_set_min/o_set_sec : last validated time, o_busy : set-time in progress
interface uart_cmd_ctrl_if;
   logic [7:0] i_rx_data;
   logic       i_rx_done;
   logic       o_run_stop;
   logic       o_clear;
   logic       o_mode_tgl;
   logic       o_set_valid;
   logic [4:0] o_set_hour;
   logic [5:0] o_set_min;
   logic [5:0] o_set_sec;
   logic       o_cmd_err;
   logic       o_busy;
   modport master (
      output i_rx_data, i_rx_done,
      input  o_run_stop, o_clear, o_mode_tgl, o_set_valid, o_set_hour, o_set_min, o_set_sec,
             o_cmd_err, o_busy
   );
   modport slave (
      input  i_rx_data, i_rx_done,
      output o_run_stop, o_clear, o_mode_tgl, o_set_valid, o_set_hour, o_set_min, o_set_sec,
             o_cmd_err, o_busy
   );
endinterface

// File: rtl/uart_cmd_ctrl.sv
// uart_cmd_ctrl: decodes ASCII bytes from uart_rx into watch control pulses and 'S'+HHMMSS set-time loads
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   bus   : uart_cmd_ctrl_if.slave (byte input, registered pulse/time/busy outputs)
module uart_cmd_ctrl #(
   parameter int TIMEOUT_CYC = 100_000_000
) (
   input logic             clk,
   input logic             rst_n,
   uart_cmd_ctrl_if.slave  bus
);
   localparam int TW = $clog2(TIMEOUT_CYC);
   typedef enum logic [1:0] {IDLE, COLLECT, CHECK} state_t;
   state_t        r_state, w_state_nx;
   logic [2:0]    r_cnt, w_cnt_nx;
   logic [TW-1:0] r_tmo, w_tmo_nx;
   logic [3:0]    r_dig [6];
   logic          r_run, r_clr, r_mode, r_set, r_err;
   logic [4:0]    r_hour;
   logic [5:0]    r_min, r_sec;
   logic [7:0]    w_lc;
   logic          w_is_r, w_is_c, w_is_m, w_is_s, w_is_eol, w_is_dig;
   logic          w_idle_byte, w_col_byte, w_tmo_end, w_ok;
   logic [6:0]    w_hh, w_mm, w_ss;
   logic          w_run, w_clr, w_mode, w_set, w_err;
   function automatic logic [6:0] to_bin(input logic [3:0] t, input logic [3:0] u);
      return ({3'b0, t} << 3) + ({3'b0, t} << 1) + {3'b0, u};
   endfunction
   // forcing bit 5 folds upper and lower case letters onto one code
   assign w_lc        = bus.i_rx_data | 8'h20;
   assign w_is_r      = w_lc == 8'h72;
   assign w_is_c      = w_lc == 8'h63;
   assign w_is_m      = w_lc == 8'h6D;
   assign w_is_s      = w_lc == 8'h73;
   assign w_is_eol    = bus.i_rx_data == 8'h0D || bus.i_rx_data == 8'h0A;
   assign w_is_dig    = bus.i_rx_data >= 8'h30 && bus.i_rx_data <= 8'h39;
   assign w_idle_byte = r_state == IDLE && bus.i_rx_done;
   assign w_col_byte  = r_state == COLLECT && bus.i_rx_done;
   assign w_tmo_end   = r_tmo == TW'(TIMEOUT_CYC - 1);
   assign w_hh        = to_bin(r_dig[0], r_dig[1]);
   assign w_mm        = to_bin(r_dig[2], r_dig[3]);
   assign w_ss        = to_bin(r_dig[4], r_dig[5]);
   assign w_ok        = w_hh <= 7'd23 && w_mm <= 7'd59 && w_ss <= 7'd59;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_tmo   <= '0;
         for (int i = 0; i < 6; i++) r_dig[i] <= '0;
      end else begin
         r_state <= w_state_nx;
         r_cnt   <= w_cnt_nx;
         r_tmo   <= w_tmo_nx;
         if (w_col_byte && w_is_dig) r_dig[r_cnt] <= bus.i_rx_data[3:0];
      end
   end
   // a byte arriving on the terminal timeout cycle takes priority over the timeout
   always_comb begin
      w_state_nx = r_state;
      w_cnt_nx   = r_cnt;
      w_tmo_nx   = r_tmo;
      case (r_state)
         IDLE: if (bus.i_rx_done && w_is_s) begin
            w_state_nx = COLLECT;
            w_cnt_nx   = '0;
            w_tmo_nx   = '0;
         end
         COLLECT: if (bus.i_rx_done) begin
            w_tmo_nx = '0;
            if (w_is_dig) begin
               w_cnt_nx   = r_cnt + 3'd1;
               w_state_nx = r_cnt == 3'd5 ? CHECK : COLLECT;
            end else if (w_is_s) w_cnt_nx = '0;
            else w_state_nx = IDLE;
         end else if (w_tmo_end) w_state_nx = IDLE;
         else w_tmo_nx = r_tmo + 1'b1;
         default: w_state_nx = IDLE;
      endcase
   end
   always_comb begin
      w_run  = w_idle_byte && w_is_r;
      w_clr  = w_idle_byte && w_is_c;
      w_mode = w_idle_byte && w_is_m;
      w_set  = r_state == CHECK && w_ok;
      w_err  = (w_idle_byte && !(w_is_r || w_is_c || w_is_m || w_is_s || w_is_eol)) ||
               (w_col_byte && !w_is_dig && !w_is_s) ||
               (r_state == COLLECT && !bus.i_rx_done && w_tmo_end) ||
               (r_state == CHECK && !w_ok);
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         {r_run, r_clr, r_mode, r_set, r_err} <= '0;
         r_hour <= '0;
         r_min  <= '0;
         r_sec  <= '0;
      end else begin
         {r_run, r_clr, r_mode, r_set, r_err} <= {w_run, w_clr, w_mode, w_set, w_err};
         if (w_set) begin
            r_hour <= w_hh[4:0];
            r_min  <= w_mm[5:0];
            r_sec  <= w_ss[5:0];
         end
      end
   end
   assign bus.o_run_stop  = r_run;
   assign bus.o_clear     = r_clr;
   assign bus.o_mode_tgl  = r_mode;
   assign bus.o_set_valid = r_set;
   assign bus.o_cmd_err   = r_err;
   assign bus.o_set_hour  = r_hour;
   assign bus.o_set_min   = r_min;
   assign bus.o_set_sec   = r_sec;
   assign bus.o_busy      = r_state != IDLE;
endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// tb_uart_cmd_ctrl: directed stimulus, command-level reference model compared every cycle, plus literal pins
module tb_uart_cmd_ctrl;
   localparam int T = 50;
   logic clk = 1'b0;
   logic rst_n = 1'b1;
   int tests = 0;
   int fails = 0;
   uart_cmd_ctrl_if bus();
   uart_cmd_ctrl #(.TIMEOUT_CYC(T)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
   always #5 clk = ~clk;
   bit m_cmd, m_chk;
   int m_idle, hh, mm, ss, n;
   int q[$];
   logic [7:0] b;
   logic e_run, e_clr, e_mode, e_set, e_err, e_busy;
   logic [4:0] e_h;
   logic [5:0] e_m, e_s;
   logic [22:0] got, exp;
   task automatic chk(input string name, input int g, input int e);
      tests++;
      if (g !== e) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d", name, g, e);
      end
   endtask
   task automatic model_reset();
      m_cmd = 0; m_chk = 0; m_idle = 0; q.delete();
      {e_run, e_clr, e_mode, e_set, e_err, e_busy} = '0;
      e_h = '0; e_m = '0; e_s = '0;
   endtask
   task automatic model_step();
      {e_run, e_clr, e_mode, e_set, e_err} = '0;
      b = bus.i_rx_data;
      if (m_chk) begin
         hh = q[0] * 10 + q[1];
         mm = q[2] * 10 + q[3];
         ss = q[4] * 10 + q[5];
         if (hh <= 23 && mm <= 59 && ss <= 59) begin
            e_set = 1; e_h = 5'(hh); e_m = 6'(mm); e_s = 6'(ss);
         end else e_err = 1;
         m_chk = 0;
      end else if (m_cmd) begin
         if (bus.i_rx_done) begin
            m_idle = 0;
            if (b >= "0" && b <= "9") begin
               q.push_back(int'(b) - 48);
               if (q.size() == 6) begin m_cmd = 0; m_chk = 1; end
            end else if (b == "S" || b == "s") q.delete();
            else begin e_err = 1; m_cmd = 0; end
         end else begin
            m_idle++;
            if (m_idle == T) begin e_err = 1; m_cmd = 0; end
         end
      end else if (bus.i_rx_done) begin
         if (b == "R" || b == "r") e_run = 1;
         else if (b == "C" || b == "c") e_clr = 1;
         else if (b == "M" || b == "m") e_mode = 1;
         else if (b == "S" || b == "s") begin m_cmd = 1; m_idle = 0; q.delete(); end
         else if (b != 8'h0D && b != 8'h0A) e_err = 1;
      end
      e_busy = m_cmd || m_chk;
   endtask
   task automatic cmp_cycle();
      got = {bus.o_run_stop, bus.o_clear, bus.o_mode_tgl, bus.o_set_valid, bus.o_cmd_err,
             bus.o_busy, bus.o_set_hour, bus.o_set_min, bus.o_set_sec};
      exp = {e_run, e_clr, e_mode, e_set, e_err, e_busy, e_h, e_m, e_s};
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL cycle_model t=%0t: got run/clr/mode/set/err/busy=%b h=%0d m=%0d s=%0d, expected %b h=%0d m=%0d s=%0d",
                  $time, got[22:17], got[16:12], got[11:6], got[5:0], exp[22:17], exp[16:12], exp[11:6], exp[5:0]);
      end
   endtask
   task automatic strobe(input logic [7:0] v);
      @(negedge clk);
      bus.i_rx_data = v;
      bus.i_rx_done = 1'b1;
      @(negedge clk);
      bus.i_rx_done = 1'b0;
   endtask
   task automatic idle(input int k);
      repeat (k) @(negedge clk);
   endtask
   task automatic send(input string s);
      for (int i = 0; i < s.len(); i++) begin
         strobe(s[i]);
         idle(2);
      end
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
   initial begin
      bus.i_rx_data = '0;
      bus.i_rx_done = 1'b0;
      fork
         forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else model_step();
         end
         forever begin
            @(negedge clk);
            if (rst_n) cmp_cycle();
         end
      join_none
      #1 rst_n = 1'b0;
      #2 chk("reset_outputs", int'({bus.o_run_stop, bus.o_clear, bus.o_mode_tgl, bus.o_set_valid,
                                   bus.o_cmd_err, bus.o_busy, bus.o_set_hour, bus.o_set_min, bus.o_set_sec}), 0);
      idle(2);
      #2 rst_n = 1'b1;
      idle(2);
      // single-byte commands
      strobe("R");
      chk("run_stop_pulse", int'(bus.o_run_stop), 1);
      strobe("c");
      chk("clear_pulse", int'(bus.o_clear), 1);
      strobe("m");
      chk("mode_pulse", int'(bus.o_mode_tgl), 1);
      idle(2);
      // valid set-time at the upper limits
      send("S23595");
      strobe("9");
      chk("busy_in_check", int'(bus.o_busy), 1);
      idle(1);
      chk("set_valid_2359", int'(bus.o_set_valid), 1);
      chk("set_hour_23", int'(bus.o_set_hour), 23);
      chk("set_min_59", int'(bus.o_set_min), 59);
      chk("set_sec_59", int'(bus.o_set_sec), 59);
      idle(2);
      // out-of-range hour and minute
      send("S24590");
      strobe("0");
      idle(1);
      chk("hour24_err", int'(bus.o_cmd_err), 1);
      chk("hour24_keep", int'(bus.o_set_hour), 23);
      send("S12600");
      strobe("0");
      idle(1);
      chk("min60_err", int'(bus.o_cmd_err), 1);
      chk("min60_keep", int'(bus.o_set_min), 59);
      chk("min60_idle", int'(bus.o_busy), 0);
      idle(2);
      // inter-byte timeout
      send("S1");
      strobe("2");
      n = 1;
      while (!bus.o_cmd_err && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("timeout_latency", n, T + 1);
      chk("timeout_idle", int'(bus.o_busy), 0);
      send("S01020");
      strobe("3");
      idle(1);
      chk("set_010203_valid", int'(bus.o_set_valid), 1);
      chk("set_010203", int'({bus.o_set_hour, bus.o_set_min, bus.o_set_sec}), (1 << 12) | (2 << 6) | 3);
      idle(2);
      // bad bytes, CR/LF, restart
      send("S1");
      strobe("x");
      chk("bad_digit_err", int'(bus.o_cmd_err), 1);
      idle(1);
      strobe("Z");
      chk("unknown_err", int'(bus.o_cmd_err), 1);
      strobe(8'h0D);
      chk("cr_ignored", int'(bus.o_cmd_err), 0);
      strobe(8'h0A);
      chk("lf_ignored", int'(bus.o_cmd_err), 0);
      send("S12S00000");
      strobe("5");
      idle(1);
      chk("restart_valid", int'(bus.o_set_valid), 1);
      chk("restart_time", int'({bus.o_set_hour, bus.o_set_min, bus.o_set_sec}), 5);
      idle(2);
      // byte landing in the evaluation cycle is dropped silently
      send("S07080");
      strobe("9");
      bus.i_rx_data = "Z";
      bus.i_rx_done = 1'b1;
      @(negedge clk);
      bus.i_rx_done = 1'b0;
      chk("check_drop_valid", int'(bus.o_set_valid), 1);
      chk("check_drop_time", int'({bus.o_set_hour, bus.o_set_min, bus.o_set_sec}), (7 << 12) | (8 << 6) | 9);
      idle(1);
      chk("check_drop_noerr", int'(bus.o_cmd_err), 0);
      // reset in the middle of a set-time command
      send("S123");
      strobe("4");
      #2 rst_n = 1'b0;
      #1 chk("midrst_outputs", int'({bus.o_run_stop, bus.o_clear, bus.o_mode_tgl, bus.o_set_valid,
                                    bus.o_cmd_err, bus.o_busy, bus.o_set_hour, bus.o_set_min, bus.o_set_sec}), 0);
      idle(2);
      #2 rst_n = 1'b1;
      idle(1);
      send("S00000");
      strobe("1");
      idle(1);
      chk("post_rst_valid", int'(bus.o_set_valid), 1);
      chk("post_rst_sec", int'(bus.o_set_sec), 1);
      strobe("R");
      chk("post_rst_run", int'(bus.o_run_stop), 1);
      idle(5);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
